// File: rtl/ap_prof_pkg.sv
// ap_prof_pkg: shared types for the ap_ctrl protocol profiler.
//   ap_state_e : profiler FSM state (also exported on the debug port).
//   ap_rec_t   : one transaction record at the default widths (32-bit timing,
//                16-bit index). ap_ctrl_profiler declares the same layout at
//                its own parameter widths and hands it to the FIFO as a type.
// Optional feature macro: AP_CTRL_PROF_STALL_EN adds the stall and
// first-ready fields to the record.
package ap_prof_pkg;

  localparam int AP_CNT_W = 32;
  localparam int AP_IDX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BUSY      = 2'd1,
    ST_WAIT_CONT = 2'd2
  } ap_state_e;

  typedef struct packed {
    logic [AP_IDX_W-1:0] idx;
    logic [AP_CNT_W-1:0] start;
    logic [AP_CNT_W-1:0] latency;
    logic [AP_CNT_W-1:0] interval;
`ifdef AP_CTRL_PROF_STALL_EN
    logic [AP_CNT_W-1:0] stall;
    logic [AP_CNT_W-1:0] ready_cyc;
`endif
  } ap_rec_t;

endpackage

// File: rtl/ap_prof_fifo.sv
// ap_prof_fifo: synchronous FIFO of profiler records.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   push, push_data     write request and record; ignored when full unless a
//                       pop happens in the same cycle
//   pop, pop_data       read request (ignored when empty) and head record;
//                       the head is read straight from storage, so it stays
//                       stable until popped
//   full, empty         occupancy flags
// Parameters: rec_t (record type), DEPTH (power of two, >= 2).
module ap_prof_fifo
  import ap_prof_pkg::*;
#(
  parameter type rec_t = ap_rec_t,
  parameter int  DEPTH = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  rec_t push_data,
  input  logic pop,
  output rec_t pop_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  rec_t        mem [DEPTH];
  logic        push_ok;
  logic        pop_ok;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok   = pop && !empty;
  // When full, the slot being written is the head being popped this edge.
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ap_ctrl_profiler.sv
// ap_ctrl_profiler: watches an ap_ctrl_hs style kernel handshake and emits one
// timing record per transaction (index, start cycle, latency, start interval).
// Ports:
//   clock, reset                  rising-edge clock, sync active-high reset
//   ap_start/ready/done/continue  sampled kernel handshake
//   finish                        stop capturing new transactions
//   rec_valid/rec_ready, rec_*    record stream
//   rec_stall, rec_ready_cyc      only with AP_CTRL_PROF_STALL_EN
//   overflow, drop_count          sticky drop flag, saturating drop count
//   all_done                      finish seen, idle and all records drained
//   dbg_state                     current FSM state
// Optional feature macro: AP_CTRL_PROF_STALL_EN (stall / first-ready fields).
//
// Record stream: a record transfers on a rising edge where rec_valid and
// rec_ready are both high. rec_valid never depends on rec_ready, and once
// rec_valid is high the rec_* fields hold until that transfer.
module ap_ctrl_profiler
  import ap_prof_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int IDX_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [IDX_W-1:0] rec_idx,
  output logic [CNT_W-1:0] rec_start,
  output logic [CNT_W-1:0] rec_latency,
  output logic [CNT_W-1:0] rec_interval,
`ifdef AP_CTRL_PROF_STALL_EN
  output logic [CNT_W-1:0] rec_stall,
  output logic [CNT_W-1:0] rec_ready_cyc,
`endif
  output logic             overflow,
  output logic [IDX_W-1:0] drop_count,
  output logic             all_done,
  output ap_state_e        dbg_state
);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] start;
    logic [CNT_W-1:0] latency;
    logic [CNT_W-1:0] interval;
`ifdef AP_CTRL_PROF_STALL_EN
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] ready_cyc;
`endif
  } rec_t;

  ap_state_e        state, state_nxt;
  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] start_q, latency_q, interval_q, prev_start;
  logic [IDX_W-1:0] idx_q, drop_q;
  logic             finish_seen, overflow_q, all_done_q;

  logic             capture, complete, push_req, pop, drop;
  logic [CNT_W-1:0] cur_start, cur_latency, cur_interval;
  rec_t             push_rec, head_rec;
  logic             fifo_full, fifo_empty;

`ifdef AP_CTRL_PROF_STALL_EN
  logic [CNT_W-1:0] stall_q, cur_stall;
  logic [CNT_W-1:0] rdy_cyc_q, cur_rdy_cyc;
  logic             rdy_seen_q, cur_rdy_seen;
`else
  logic             unused_ready;
  assign unused_ready = ap_ready;
`endif

  // Next state and the record fields as they stand this cycle. A capture
  // and a completion can coincide in IDLE, so fields come from the live
  // counter rather than only from registers.
  always_comb begin
    state_nxt    = state;
    capture      = 1'b0;
    complete     = 1'b0;
    push_req     = 1'b0;
    cur_start    = start_q;
    cur_latency  = latency_q;
    cur_interval = interval_q;
    case (state)
      ST_IDLE: begin
        if (ap_start && !finish_seen) begin
          capture      = 1'b1;
          cur_start    = cyc;
          cur_latency  = '0;
          cur_interval = (idx_q == '0) ? '0 : (cyc - prev_start);
          state_nxt    = ST_BUSY;
          if (ap_done) begin
            complete = 1'b1;
            if (ap_continue) begin
              push_req  = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              state_nxt = ST_WAIT_CONT;
            end
          end
        end
      end
      ST_BUSY: begin
        cur_latency = cyc - start_q;
        if (ap_done) begin
          complete = 1'b1;
          if (ap_continue) begin
            push_req  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_WAIT_CONT;
          end
        end
      end
      ST_WAIT_CONT: begin
        if (ap_continue) begin
          push_req  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef AP_CTRL_PROF_STALL_EN
  // Stall counts WAIT_CONT cycles including the one where continue arrives.
  // First-ready is the cycle of the first ap_ready from the capture cycle up
  // to the push; 0 if ap_ready never rose.
  always_comb begin
    cur_stall    = (state == ST_WAIT_CONT) ? (stall_q + CNT_W'(1)) : '0;
    cur_rdy_seen = 1'b0;
    cur_rdy_cyc  = '0;
    if (state == ST_IDLE) begin
      cur_rdy_seen = ap_ready;
      cur_rdy_cyc  = ap_ready ? cyc : '0;
    end else begin
      cur_rdy_seen = rdy_seen_q | ap_ready;
      cur_rdy_cyc  = rdy_seen_q ? rdy_cyc_q : (ap_ready ? cyc : '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q    <= '0;
      rdy_cyc_q  <= '0;
      rdy_seen_q <= 1'b0;
    end else begin
      stall_q    <= (state == ST_WAIT_CONT) ? cur_stall : '0;
      rdy_cyc_q  <= cur_rdy_cyc;
      rdy_seen_q <= cur_rdy_seen;
    end
  end
`endif

  always_comb begin
    push_rec          = '0;
    push_rec.idx      = idx_q;
    push_rec.start    = cur_start;
    push_rec.latency  = cur_latency;
    push_rec.interval = cur_interval;
`ifdef AP_CTRL_PROF_STALL_EN
    push_rec.stall     = cur_stall;
    push_rec.ready_cyc = cur_rdy_cyc;
`endif
  end

  assign pop  = !fifo_empty && rec_ready;
  assign drop = push_req && fifo_full && !pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      cyc         <= '0;
      start_q     <= '0;
      latency_q   <= '0;
      interval_q  <= '0;
      prev_start  <= '0;
      idx_q       <= '0;
      drop_q      <= '0;
      overflow_q  <= 1'b0;
      finish_seen <= 1'b0;
      all_done_q  <= 1'b0;
    end else begin
      state       <= state_nxt;
      cyc         <= cyc + CNT_W'(1);
      finish_seen <= finish_seen | finish;
      if (capture) begin
        start_q    <= cur_start;
        interval_q <= cur_interval;
        prev_start <= cyc;
      end
      if (complete) latency_q <= cur_latency;
      // Index advances on every push attempt, dropped or not.
      if (push_req) idx_q <= idx_q + IDX_W'(1);
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != '1) drop_q <= drop_q + IDX_W'(1);
      end
      if (finish_seen && (state == ST_IDLE) && fifo_empty) all_done_q <= 1'b1;
    end
  end

  ap_prof_fifo #(
    .rec_t (rec_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_req && !drop),
    .push_data (push_rec),
    .pop       (pop),
    .pop_data  (head_rec),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rec_valid     = !fifo_empty;
  assign rec_idx       = head_rec.idx;
  assign rec_start     = head_rec.start;
  assign rec_latency   = head_rec.latency;
  assign rec_interval  = head_rec.interval;
`ifdef AP_CTRL_PROF_STALL_EN
  assign rec_stall     = head_rec.stall;
  assign rec_ready_cyc = head_rec.ready_cyc;
`endif
  assign overflow      = overflow_q;
  assign drop_count    = drop_q;
  assign all_done      = all_done_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_ap_ctrl_profiler.sv
// Testbench for ap_ctrl_profiler: directed transactions on a default-width
// instance plus a narrow-counter instance for the wrap case. Build with
// AP_CTRL_PROF_STALL_EN to include the stall / first-ready fields.
module tb_ap_ctrl_profiler;
  import ap_prof_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int tb_cyc = 0;
  always @(posedge clock) tb_cyc <= reset ? 0 : tb_cyc + 1;

  // ---------------- main DUT ----------------
  logic        ap_start = 0, ap_ready = 0, ap_done = 0, ap_continue = 0;
  logic        finish = 0, rec_ready = 0;
  logic        rec_valid, overflow, all_done;
  logic [15:0] rec_idx, drop_count;
  logic [31:0] rec_start, rec_latency, rec_interval;
  ap_state_e   dbg_state;
`ifdef AP_CTRL_PROF_STALL_EN
  logic [31:0] rec_stall, rec_ready_cyc;
`endif

  ap_ctrl_profiler u_dut (
    .clock(clock), .reset(reset),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .finish(finish), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_idx(rec_idx), .rec_start(rec_start), .rec_latency(rec_latency), .rec_interval(rec_interval),
`ifdef AP_CTRL_PROF_STALL_EN
    .rec_stall(rec_stall), .rec_ready_cyc(rec_ready_cyc),
`endif
    .overflow(overflow), .drop_count(drop_count), .all_done(all_done), .dbg_state(dbg_state)
  );

  // ---------------- narrow-counter DUT (wrap case) ----------------
  logic       w_start = 0, w_ready = 0, w_done = 0, w_cont = 0, w_finish = 0, w_rec_ready = 0;
  logic       w_rec_valid, w_overflow, w_all_done;
  logic [3:0] w_rec_idx, w_drop_count;
  logic [7:0] w_rec_start, w_rec_latency, w_rec_interval;
  ap_state_e  w_state;
`ifdef AP_CTRL_PROF_STALL_EN
  logic [7:0] w_rec_stall, w_rec_ready_cyc;
`endif

  ap_ctrl_profiler #(.CNT_W(8), .IDX_W(4), .FIFO_DEPTH(2)) u_wrap (
    .clock(clock), .reset(reset),
    .ap_start(w_start), .ap_ready(w_ready), .ap_done(w_done), .ap_continue(w_cont),
    .finish(w_finish), .rec_valid(w_rec_valid), .rec_ready(w_rec_ready),
    .rec_idx(w_rec_idx), .rec_start(w_rec_start), .rec_latency(w_rec_latency), .rec_interval(w_rec_interval),
`ifdef AP_CTRL_PROF_STALL_EN
    .rec_stall(w_rec_stall), .rec_ready_cyc(w_rec_ready_cyc),
`endif
    .overflow(w_overflow), .drop_count(w_drop_count), .all_done(w_all_done), .dbg_state(w_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [255:0] exp_q[$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mk_rec(input int idx, input int start, input int lat,
                                          input int intv, input int stall, input int rcyc);
    logic [255:0] r;
    logic [15:0]  i16;
    i16 = idx[15:0];
`ifdef AP_CTRL_PROF_STALL_EN
    r = {80'd0, i16, start, lat, intv, stall, rcyc};
`else
    r = {144'd0, i16, start, lat, intv};
    if (stall != rcyc) r = r; // stall / first-ready not present in this build
`endif
    return r;
  endfunction

  // Every record handed over is compared against the head of the queue.
  always @(negedge clock) begin
    if (!reset && rec_valid && rec_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rec", {240'd0, rec_idx}, 256'd0 - 1);
      end else begin
`ifdef AP_CTRL_PROF_STALL_EN
        check("rec", {80'd0, rec_idx, rec_start, rec_latency, rec_interval, rec_stall, rec_ready_cyc},
              exp_q.pop_front());
`else
        check("rec", {144'd0, rec_idx, rec_start, rec_latency, rec_interval}, exp_q.pop_front());
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge; when tb_cyc == n the next
  // edge samples them with the DUT counter at n.
  task automatic wait_cyc(input int n);
    int guard = 0;
    while (tb_cyc != n && guard < 5000) begin
      @(posedge clock); #1;
      guard++;
    end
    if (tb_cyc != n) check("wait_cyc_timeout", tb_cyc, n);
  endtask

  task automatic drive_at(input int n, input logic s, input logic d, input logic c, input logic r);
    wait_cyc(n);
    ap_start = s; ap_done = d; ap_continue = c; ap_ready = r;
    @(posedge clock); #1;
    ap_start = 0; ap_done = 0; ap_continue = 0; ap_ready = 0;
  endtask

  task automatic apply_reset();
    reset = 1;
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    // Reset state
    @(posedge clock); #1;
    apply_reset();
    check("rst_rec_valid", rec_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_all_done", all_done, 0);
    check("rst_state", dbg_state, ST_IDLE);

    // Basic transactions
    rec_ready = 1;
    exp_q.push_back(mk_rec(0, 10, 4, 0, 0, 0));
    drive_at(10, 1, 0, 0, 0);
    drive_at(12, 1, 0, 0, 0);                 // ignored while BUSY
    check("busy_state", dbg_state, ST_BUSY);
    drive_at(14, 0, 1, 1, 0);

    exp_q.push_back(mk_rec(1, 20, 2, 10, 0, 0));
    drive_at(20, 1, 0, 0, 0);
    drive_at(22, 0, 1, 1, 0);

    // Continue held low after done
    exp_q.push_back(mk_rec(2, 30, 3, 10, 3, 31));
    drive_at(30, 1, 0, 0, 0);
    drive_at(31, 0, 0, 0, 1);
    drive_at(33, 0, 1, 0, 0);
    check("wait_state", dbg_state, ST_WAIT_CONT);
    drive_at(35, 0, 1, 0, 0);                 // done ignored in WAIT_CONT
    check("no_rec_before_cont", rec_valid, 0);
    drive_at(36, 0, 0, 1, 0);

    // Start, done and continue in one cycle: latency 0
    exp_q.push_back(mk_rec(3, 40, 0, 10, 0, 0));
    drive_at(40, 1, 1, 1, 0);
    wait_cyc(45);
    check("s1_drained", rec_valid, 0);
    check("s1_queue_empty", exp_q.size(), 0);
    check("s1_overflow", overflow, 0);

    // Overflow: 10 transactions into a depth-8 FIFO with no reader
    rec_ready = 0;
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      if (k < 8) exp_q.push_back(mk_rec(k, 10 + 4 * k, 1, (k == 0) ? 0 : 4, 0, 0));
      drive_at(10 + 4 * k, 1, 0, 0, 0);
      drive_at(11 + 4 * k, 0, 1, 1, 0);
    end
    wait_cyc(55);
    check("ovf_flag", overflow, 1);
    check("ovf_drop_count", drop_count, 2);
    check("ovf_rec_valid", rec_valid, 1);
    check("ovf_head_idx", rec_idx, 0);
    check("ovf_head_start", rec_start, 10);
    wait_cyc(58);
    check("stable_idx", rec_idx, 0);
    check("stable_start", rec_start, 10);
    // Push into a full FIFO together with a pop is accepted
    exp_q.push_back(mk_rec(10, 60, 0, 14, 0, 0));
    wait_cyc(60);
    rec_ready = 1;
    drive_at(60, 1, 1, 1, 0);
    wait_cyc(75);
    check("full_pop_push_drops", drop_count, 2);
    check("s2_drained", rec_valid, 0);
    check("s2_queue_empty", exp_q.size(), 0);

    // Finish during BUSY
    apply_reset();
    rec_ready = 1;
    check("rst2_overflow", overflow, 0);
    exp_q.push_back(mk_rec(0, 10, 5, 0, 0, 0));
    drive_at(10, 1, 0, 0, 0);
    wait_cyc(12);
    finish = 1;
    @(posedge clock); #1;
    finish = 0;
    check("fin_busy_all_done", all_done, 0);
    drive_at(15, 0, 1, 1, 0);
    wait_cyc(17);
    check("all_done_not_yet", all_done, 0);
    wait_cyc(18);
    check("all_done_rise", all_done, 1);
    drive_at(20, 1, 1, 1, 0);                 // not captured after finish
    wait_cyc(25);
    check("fin_no_new_rec", rec_valid, 0);
    check("fin_state", dbg_state, ST_IDLE);
    check("all_done_sticky", all_done, 1);
    check("s3_queue_empty", exp_q.size(), 0);

    // Counter wrap on the 8-bit instance: start at 254, done 3 cycles later
    apply_reset();
    wait_cyc(254);
    w_start = 1;
    @(posedge clock); #1;
    w_start = 0;
    wait_cyc(257);
    w_done = 1; w_cont = 1;
    @(posedge clock); #1;
    w_done = 0; w_cont = 0;
    wait_cyc(259);
    check("wrap_valid", w_rec_valid, 1);
    check("wrap_idx", w_rec_idx, 0);
    check("wrap_start", w_rec_start, 254);
    check("wrap_latency", w_rec_latency, 3);
    check("wrap_interval", w_rec_interval, 0);
    check("wrap_overflow", {w_overflow, w_drop_count, w_all_done}, 0);
    check("wrap_state", w_state, ST_IDLE);
`ifdef AP_CTRL_PROF_STALL_EN
    check("wrap_stall", {w_rec_stall, w_rec_ready_cyc}, 0);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
